// File: rtl/vga_code_scheduler_pkg.sv
// Purpose: shared widths, VGA timing constants and control-state type for the code scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_code_scheduler_pkg;

  // Colour code layout: {left[11:0], right[11:0]}, each 4/4/4 RGB.
  localparam int CODE_W  = 24;
  localparam int COLOR_W = 12;

  // 800x600 timing shared with the VGA generator: visible/front/sync/back.
  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 56;
  localparam int H_SYNC    = 120;
  localparam int H_BACK    = 64;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 37;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 23;

  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL;

  // IDLE: nothing queued. PENDING: entries waiting for an eligible frame tick.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } sched_state_t;

  // Build a full code from its left and right half colours.
  function automatic logic [CODE_W-1:0] pack_code(input logic [COLOR_W-1:0] left,
                                                  input logic [COLOR_W-1:0] right);
    return {left, right};
  endfunction

endpackage

// File: rtl/vga_code_scheduler_sync_fifo.sv
// Purpose: generic synchronous FIFO with occupancy count; head is the oldest entry.
// Latency: a push is visible at head/level on the next cycle; first-word fall-through head.
// Backpressure: ready is low when full, from registered count only (a same-cycle pop does not free a slot).
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign ready   = (count != (AW+1)'(DEPTH));
  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks net push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; writes are dropped while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_code_scheduler.sv
// Purpose: queue colour codes and apply at most one per frame on the vsync rising edge.
// Latency: code updates one clk after an eligible vsync rise; entries wait >= HOLD_FRAMES frames apart.
// Backpressure: wr_ready follows FIFO fullness from registered level; no path from wr_valid.
module vga_code_scheduler
  import vga_code_scheduler_pkg::*;
#(
  parameter int              DEPTH       = 4,
  parameter int              HOLD_FRAMES = 1,
  parameter logic [CODE_W-1:0] RESET_CODE = 24'h000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [CODE_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   vsync,
  output logic [CODE_W-1:0]      code,
  output logic [$clog2(DEPTH):0] level,
  output logic                   updated
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

  logic              vsync_d;
  logic              frame_tick;
  logic [HW-1:0]     hold_cnt;
  sched_state_t      state;
  logic              push;
  logic              pop;
  logic              fifo_ready;
  logic [CODE_W-1:0] head;
  logic [LW-1:0]     level_next;

  assign frame_tick = vsync & ~vsync_d;
  assign push       = wr_valid && fifo_ready;
  assign pop        = frame_tick && (state == ST_PENDING) && (hold_cnt == HOLD_MAX);
  assign wr_ready   = fifo_ready;
  assign level_next = level + LW'(push) - LW'(pop);

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .ready     (fifo_ready)
  );

  // Edge detect, hold counting, control state and the registered code output.
  // vsync_d resets high so a vsync already asserted at reset release is not a tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d  <= 1'b1;
      hold_cnt <= '0;
      state    <= ST_IDLE;
      code     <= RESET_CODE;
      updated  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      updated <= pop;
      if (pop) begin
        code     <= head;
        hold_cnt <= '0;
      end else if (frame_tick && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      state <= (level_next != '0) ? ST_PENDING : ST_IDLE;
    end
  end

endmodule

// File: tb/tb_vga_code_scheduler.sv
// Purpose: scoreboard bench for vga_code_scheduler with HOLD_FRAMES=1 and HOLD_FRAMES=3 instances.
// Latency: expects code one clk after an eligible vsync rise.
// Backpressure: writers hold wr_valid/wr_data until wr_ready is seen high.
module tb_vga_code_scheduler;
  import vga_code_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int H0    = 1;
  localparam int H3    = 3;
  localparam logic [23:0] RST_CODE = 24'h000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b1;
  logic        wr_valid0 = 1'b0, wr_valid3 = 1'b0;
  logic [23:0] wr_data0 = '0, wr_data3 = '0;
  logic        wr_ready0, wr_ready3;
  logic [23:0] code0, code3;
  logic [2:0]  level0, level3;
  logic        updated0, updated3;

  int n_chk = 0;
  int n_fail = 0;

  // pending writes (not yet accepted) and scoreboard (accepted, not yet displayed)
  logic [23:0] wq0[$], wq3[$];
  logic [23:0] e0[$], e3[$];

  // monitor model state
  logic        p_rst = 1'b0, p_vs = 1'b1, p_acc0 = 1'b0, p_acc3 = 1'b0;
  logic [23:0] p_d0 = '0, p_d3 = '0;
  logic        vs_last = 1'b1;
  logic        tick, pop0, pop3;
  logic [23:0] c0 = '0, c3 = '0;
  int          h0 = 0, h3 = 0;

  // snapshots taken in frame()
  logic        s_u0, s_u3, s_u0b, s_u3b;
  logic [23:0] s_c0, s_c3;
  logic [2:0]  s_l0;
  logic [23:0] seq [5];

  always #5 clk = ~clk;

  vga_code_scheduler #(.DEPTH(DEPTH), .HOLD_FRAMES(H0), .RESET_CODE(RST_CODE)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid0), .wr_data(wr_data0), .wr_ready(wr_ready0),
    .vsync(vsync), .code(code0), .level(level0), .updated(updated0)
  );

  vga_code_scheduler #(.DEPTH(DEPTH), .HOLD_FRAMES(H3), .RESET_CODE(RST_CODE)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid3), .wr_data(wr_data3), .wr_ready(wr_ready3),
    .vsync(vsync), .code(code3), .level(level3), .updated(updated3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: evaluate the edge just passed using inputs latched at the previous negedge.
  always @(negedge clk) begin
    pop0 = 1'b0;
    pop3 = 1'b0;
    if (!p_rst) begin
      e0.delete(); e3.delete();
      c0 = RST_CODE; c3 = RST_CODE;
      h0 = 0; h3 = 0;
      vs_last = 1'b1;
    end else begin
      tick = p_vs && !vs_last;
      vs_last = p_vs;
      pop0 = tick && (e0.size() > 0) && (h0 == H0 - 1);
      pop3 = tick && (e3.size() > 0) && (h3 == H3 - 1);
      if (pop0) begin c0 = e0.pop_front(); h0 = 0; end
      else if (tick && h0 < H0 - 1) h0++;
      if (pop3) begin c3 = e3.pop_front(); h3 = 0; end
      else if (tick && h3 < H3 - 1) h3++;
      if (p_acc0) e0.push_back(p_d0);
      if (p_acc3) e3.push_back(p_d3);
    end
    chk("upd0", updated0, pop0);
    chk("code0", code0, c0);
    chk("lvl0", level0, e0.size());
    chk("rdy0", wr_ready0, e0.size() < DEPTH);
    chk("upd3", updated3, pop3);
    chk("code3", code3, c3);
    chk("lvl3", level3, e3.size());
    chk("rdy3", wr_ready3, e3.size() < DEPTH);
    p_rst  = rst_n;
    p_vs   = vsync;
    p_acc0 = wr_valid0 && wr_ready0;
    p_acc3 = wr_valid3 && wr_ready3;
    p_d0   = wr_data0;
    p_d3   = wr_data3;
  end

  // One clock of stimulus: drive vsync and the head of each write queue, retire accepted writes.
  task automatic cyc(input logic vs);
    logic a0, a3;
    vsync = vs;
    wr_valid0 = (wq0.size() != 0);
    if (wr_valid0) wr_data0 = wq0[0];
    wr_valid3 = (wq3.size() != 0);
    if (wr_valid3) wr_data3 = wq3[0];
    @(negedge clk);
    a0 = wr_valid0 && wr_ready0 && rst_n;
    a3 = wr_valid3 && wr_ready3 && rst_n;
    @(posedge clk);
    #1;
    if (a0) void'(wq0.pop_front());
    if (a3) void'(wq3.pop_front());
  endtask

  // One short synthetic frame; snapshots outputs one clk after the vsync rise.
  task automatic frame();
    cyc(1'b1);
    s_u0 = updated0; s_c0 = code0; s_l0 = level0;
    s_u3 = updated3; s_c3 = code3;
    cyc(1'b1);
    s_u0b = updated0; s_u3b = updated3;
    for (int i = 0; i < 6; i++) cyc(1'b0);
  endtask

  initial begin
    // Test 1: reset with vsync held high, release, no spurious tick.
    for (int i = 0; i < 3; i++) cyc(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("t1_no_upd", updated0, 1'b0);
    end
    chk("t1_code", code0, 24'h000000);
    chk("t1_rdy", wr_ready0, 1'b1);
    chk("t1_lvl", level0, 3'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0);

    // Test 2: single push mid-frame, applied one clk after the vsync rise.
    wq0.push_back(pack_code(12'hF00, 12'h00F));
    for (int i = 0; i < 3; i++) cyc(1'b0);
    chk("t2_lvl", level0, 3'd1);
    chk("t2_hold", code0, 24'h000000);
    frame();
    chk("t2_upd", s_u0, 1'b1);
    chk("t2_code", s_c0, 24'hF0000F);
    chk("t2_lvl0", s_l0, 3'd0);
    chk("t2_pulse", s_u0b, 1'b0);

    // Test 3: five back-to-back pushes into a 4-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      seq[i] = 24'h100000 * (i + 1) + 24'h000011 * (i + 1);
      wq0.push_back(seq[i]);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0);
    chk("t3_full_lvl", level0, 3'd4);
    chk("t3_full_rdy", wr_ready0, 1'b0);
    chk("t3_stalled", wq0.size(), 1);
    for (int i = 0; i < 5; i++) begin
      frame();
      chk("t3_upd", s_u0, 1'b1);
      chk("t3_order", s_c0, seq[i]);
    end
    chk("t3_empty", level0, 3'd0);

    // Test 5: push lands on the pop cycle with level 2.
    wq0.push_back(24'hA0A0A0);
    wq0.push_back(24'hB0B0B0);
    for (int i = 0; i < 3; i++) cyc(1'b0);
    chk("t5_lvl2", level0, 3'd2);
    wq0.push_back(24'hC0C0C0);
    frame();
    chk("t5_lvl_same", s_l0, 3'd2);
    chk("t5_code_a", s_c0, 24'hA0A0A0);
    frame();
    chk("t5_code_b", s_c0, 24'hB0B0B0);
    frame();
    chk("t5_code_c", s_c0, 24'hC0C0C0);
    chk("t5_empty", level0, 3'd0);

    // Test 4: HOLD_FRAMES=3 instance, A at tick n, B at tick n+3.
    wq3.push_back(24'h123456);
    wq3.push_back(24'h789ABC);
    for (int i = 0; i < 3; i++) cyc(1'b0);
    chk("t4_lvl", level3, 3'd2);
    frame();
    chk("t4_upd_n", s_u3, 1'b1);
    chk("t4_code_n", s_c3, 24'h123456);
    chk("t4_pulse", s_u3b, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      frame();
      chk("t4_quiet_upd", s_u3, 1'b0);
      chk("t4_quiet_code", s_c3, 24'h123456);
    end
    frame();
    chk("t4_upd_n3", s_u3, 1'b1);
    chk("t4_code_n3", s_c3, 24'h789ABC);

    // Test 6: mid-operation reset discards queued entries.
    wq0.push_back(24'h111111);
    wq0.push_back(24'h222222);
    wq0.push_back(24'h333333);
    for (int i = 0; i < 5; i++) cyc(1'b0);
    chk("t6_lvl3", level0, 3'd3);
    rst_n = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
    chk("t6_lvl", level0, 3'd0);
    chk("t6_code", code0, RST_CODE);
    chk("t6_code3", code3, RST_CODE);
    chk("t6_rdy", wr_ready0, 1'b1);
    frame();
    chk("t6_no_upd", s_u0, 1'b0);
    chk("t6_code_hold", s_c0, RST_CODE);

    chk("writes_drained", wq0.size() + wq3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
